// File: rtl/draw_screen_mode_if.sv
// Video stream bundle for draw_screen_mode: timing in, delayed timing plus background colour out.
interface draw_screen_mode_if;
  logic [11:0] hcount_in;
  logic [11:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] hcount_out;
  logic [11:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
  );
  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
  );
endinterface

// File: rtl/draw_screen_mode.sv
// Screen-mode FSM and mode-dependent background renderer, one pclk of video latency.
// Define MULTI_TIMEOUT_EN to enable the multiplayer-wait timeout (WAIT_FRAMES vsync edges).
module draw_screen_mode #(
  parameter int TOP_V_LINE    = 317,
  parameter int BOTTOM_V_LINE = 617,
  parameter int LEFT_H_LINE   = 361,
  parameter int RIGHT_H_LINE  = 661,
  parameter int BORDER        = 10,
  parameter int PLAY_X = 432, parameter int PLAY_Y = 400, parameter int PLAY_W = 128, parameter int PLAY_H = 80,
  parameter int MULTI_X = 432, parameter int MULTI_Y = 540, parameter int MULTI_W = 128, parameter int MULTI_H = 80,
  parameter int MENU_X = 432, parameter int MENU_Y = 520, parameter int MENU_W = 128, parameter int MENU_H = 80,
  parameter int OUTLINE       = 2,
  parameter int WAIT_FRAMES   = 600
) (
  input  logic              pclk,
  input  logic              rst_n,
  draw_screen_mode_if.slave vid,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              mouse_left,
  input  logic              game_on,
  input  logic              menu_on,
  input  logic              game_over,
  input  logic              victory,
  input  logic              opponent_ready,
  input  logic              pause_toggle,
  output logic [2:0]        mode,
  output logic              play_selected,
  output logic              multiplayer,
  output logic              player_ready,
  output logic              display_buttons,
  output logic              display_menu_button,
  output logic [2:0]        hover,
  output logic              wait_timeout
);
  typedef enum logic [2:0] {
    S_MENU       = 3'd0,
    S_GAME       = 3'd1,
    S_VICTORY    = 3'd2,
    S_GAME_OVER  = 3'd3,
    S_MULTI_WAIT = 3'd4,
    S_PAUSE      = 3'd5
  } state_t;

  if (WAIT_FRAMES < 1 || WAIT_FRAMES > 65535) begin : g_bad_wait_frames
    $error("draw_screen_mode: WAIT_FRAMES must be 1..65535");
  end

  function automatic logic in_box(input logic [11:0] px, input logic [11:0] py,
                                  input int x, input int y, input int w, input int h);
    int ix;
    int iy;
    ix = int'(px);
    iy = int'(py);
    return (ix >= x) && (ix <= x + w - 1) && (iy >= y) && (iy <= y + h - 1);
  endfunction

  function automatic logic on_ring(input logic [11:0] px, input logic [11:0] py,
                                   input int x, input int y, input int w, input int h, input int t);
    return in_box(px, py, x, y, w, h) && !in_box(px, py, x + t, y + t, w - 2 * t, h - 2 * t);
  endfunction

  state_t      r_state;
  logic        r_multi;
  // Holds "button was up last cycle"; clearing it on reset means a held button never clicks.
  logic        r_mouse_up;
  state_t      w_next;
  logic        w_multi_next;
  logic        w_click;
  logic        w_hit_play, w_hit_multi, w_hit_menu;
  logic        w_vis_btn, w_vis_menu, w_nvis_btn, w_nvis_menu;
  logic        w_timeout_hit;
  logic [11:0] w_rgb;

  assign w_click     = mouse_left && r_mouse_up;
  assign w_hit_play  = in_box(xpos, ypos, PLAY_X, PLAY_Y, PLAY_W, PLAY_H);
  assign w_hit_multi = in_box(xpos, ypos, MULTI_X, MULTI_Y, MULTI_W, MULTI_H);
  assign w_hit_menu  = in_box(xpos, ypos, MENU_X, MENU_Y, MENU_W, MENU_H);
  assign w_vis_btn   = (r_state == S_MENU) || (r_state == S_VICTORY) || (r_state == S_GAME_OVER);
  assign w_vis_menu  = (r_state == S_MULTI_WAIT) || (r_state == S_PAUSE);
  assign w_nvis_btn  = (w_next == S_MENU) || (w_next == S_VICTORY) || (w_next == S_GAME_OVER);
  assign w_nvis_menu = (w_next == S_MULTI_WAIT) || (w_next == S_PAUSE);
  assign mode        = r_state;

`ifdef MULTI_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_vsync_prev;
  logic        r_wait_timeout;

  assign w_timeout_hit = (r_state == S_MULTI_WAIT) && (r_wait_cnt == 16'(WAIT_FRAMES)) &&
                         !opponent_ready && !(w_click && w_hit_menu);
  assign wait_timeout  = r_wait_timeout;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_wait_cnt     <= '0;
      r_vsync_prev   <= 1'b0;
      r_wait_timeout <= 1'b0;
    end else begin
      r_vsync_prev   <= vid.vsync_in;
      r_wait_timeout <= w_timeout_hit;
      if (r_state != S_MULTI_WAIT)
        r_wait_cnt <= '0;
      else if (vid.vsync_in && !r_vsync_prev)
        r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign wait_timeout  = 1'b0;
`endif

  always_comb begin
    w_next       = r_state;
    w_multi_next = r_multi;
    case (r_state)
      S_MENU: begin
        if (game_on)                       w_next = S_GAME;
        else if (w_click && w_hit_play)  begin w_next = S_GAME;       w_multi_next = 1'b0; end
        else if (w_click && w_hit_multi) begin w_next = S_MULTI_WAIT; w_multi_next = 1'b1; end
        else if (game_over)                w_next = S_GAME_OVER;
        else if (victory)                  w_next = S_VICTORY;
      end
      S_GAME: begin
        if (menu_on)           w_next = S_MENU;
        else if (game_over)    w_next = S_GAME_OVER;
        else if (victory)      w_next = S_VICTORY;
        else if (pause_toggle) w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (menu_on)                     w_next = S_MENU;
        else if (pause_toggle)           w_next = S_GAME;
        else if (w_click && w_hit_menu)  w_next = S_MENU;
      end
      S_VICTORY, S_GAME_OVER: begin
        if (game_on)                       w_next = S_GAME;
        else if (menu_on)                  w_next = S_MENU;
        else if (w_click && w_hit_play)  begin w_next = S_GAME;       w_multi_next = 1'b0; end
        else if (w_click && w_hit_multi) begin w_next = S_MULTI_WAIT; w_multi_next = 1'b1; end
        else if (w_click)                  w_next = S_MENU;
      end
      S_MULTI_WAIT: begin
        if (opponent_ready)              w_next = S_GAME;
        else if (w_click && w_hit_menu)  w_next = S_MENU;
        else if (w_timeout_hit)          w_next = S_MENU;
      end
      default: w_next = S_MENU;
    endcase
  end

  always_comb begin
    w_rgb = 12'h000;
    if (vid.hblnk_in || vid.vblnk_in)
      w_rgb = 12'h000;
    else if (vid.vcount_in == 12'd0)    w_rgb = 12'hFF0;
    else if (vid.vcount_in == 12'd767)  w_rgb = 12'hF00;
    else if (vid.hcount_in == 12'd0)    w_rgb = 12'h0F0;
    else if (vid.hcount_in == 12'd1023) w_rgb = 12'h00F;
    else if (w_vis_btn && on_ring(vid.hcount_in, vid.vcount_in, PLAY_X, PLAY_Y, PLAY_W, PLAY_H, OUTLINE))
      w_rgb = w_hit_play ? 12'h0F0 : 12'hFFF;
    else if (w_vis_btn && on_ring(vid.hcount_in, vid.vcount_in, MULTI_X, MULTI_Y, MULTI_W, MULTI_H, OUTLINE))
      w_rgb = w_hit_multi ? 12'h0F0 : 12'hFFF;
    else if (w_vis_menu && on_ring(vid.hcount_in, vid.vcount_in, MENU_X, MENU_Y, MENU_W, MENU_H, OUTLINE))
      w_rgb = w_hit_menu ? 12'h0F0 : 12'hFFF;
    else begin
      case (r_state)
        S_GAME, S_PAUSE: begin
          if (on_ring(vid.hcount_in, vid.vcount_in, LEFT_H_LINE - BORDER, TOP_V_LINE - BORDER,
                      RIGHT_H_LINE - LEFT_H_LINE + 1 + 2 * BORDER,
                      BOTTOM_V_LINE - TOP_V_LINE + 1 + 2 * BORDER, BORDER))
            w_rgb = (r_state == S_GAME) ? 12'hFFF : 12'h888;
        end
        S_VICTORY:    w_rgb = 12'h2F2;
        S_GAME_OVER:  w_rgb = 12'hF22;
        S_MULTI_WAIT: w_rgb = 12'h22F;
        default:      w_rgb = 12'h000;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_state             <= S_MENU;
      r_multi             <= 1'b0;
      r_mouse_up          <= 1'b0;
      vid.hcount_out      <= '0;
      vid.vcount_out      <= '0;
      vid.hsync_out       <= 1'b0;
      vid.vsync_out       <= 1'b0;
      vid.hblnk_out       <= 1'b0;
      vid.vblnk_out       <= 1'b0;
      vid.rgb_out         <= '0;
      play_selected       <= 1'b0;
      multiplayer         <= 1'b0;
      player_ready        <= 1'b0;
      display_buttons     <= 1'b0;
      display_menu_button <= 1'b0;
      hover               <= '0;
    end else begin
      r_state             <= w_next;
      r_multi             <= w_multi_next;
      r_mouse_up          <= !mouse_left;
      vid.hcount_out      <= vid.hcount_in;
      vid.vcount_out      <= vid.vcount_in;
      vid.hsync_out       <= vid.hsync_in;
      vid.vsync_out       <= vid.vsync_in;
      vid.hblnk_out       <= vid.hblnk_in;
      vid.vblnk_out       <= vid.vblnk_in;
      vid.rgb_out         <= w_rgb;
      play_selected       <= (w_next == S_GAME);
      player_ready        <= (w_next == S_MULTI_WAIT);
      multiplayer         <= (w_next == S_MULTI_WAIT) ||
                             (((w_next == S_GAME) || (w_next == S_PAUSE)) && w_multi_next);
      display_buttons     <= w_nvis_btn;
      display_menu_button <= w_nvis_menu;
      hover               <= {w_hit_menu && w_nvis_menu, w_hit_multi && w_nvis_btn, w_hit_play && w_nvis_btn};
    end
  end
endmodule

// File: tb/tb_draw_screen_mode.sv
// Randomized bench for draw_screen_mode against a behavioural per-cycle model.
module tb_draw_screen_mode;
  localparam int WAIT_N = 3;
  localparam int PX = 432, PY = 400, PW = 128, PH = 80;
  localparam int NX = 432, NY = 540, NW = 128, NH = 80;
  localparam int MX = 432, MY = 520, MW = 128, MH = 80;
  localparam int TOPL = 317, BOTL = 617, LEFTL = 361, RIGHTL = 661, BRD = 10, OUTL = 2;
`ifdef MULTI_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst_n;
  logic [11:0] xpos, ypos;
  logic        mouse_left, game_on, menu_on, game_over, victory, opponent_ready, pause_toggle;
  logic [2:0]  mode, hover;
  logic        play_selected, multiplayer, player_ready, display_buttons, display_menu_button, wait_timeout;

  draw_screen_mode_if vid();

  draw_screen_mode #(.WAIT_FRAMES(WAIT_N)) dut (
    .pclk(pclk), .rst_n(rst_n), .vid(vid),
    .xpos(xpos), .ypos(ypos), .mouse_left(mouse_left),
    .game_on(game_on), .menu_on(menu_on), .game_over(game_over), .victory(victory),
    .opponent_ready(opponent_ready), .pause_toggle(pause_toggle),
    .mode(mode), .play_selected(play_selected), .multiplayer(multiplayer),
    .player_ready(player_ready), .display_buttons(display_buttons),
    .display_menu_button(display_menu_button), .hover(hover), .wait_timeout(wait_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model state: 0 MENU, 1 GAME, 2 VICTORY, 3 GAME_OVER, 4 MULTI_WAIT, 5 PAUSE
  int m_state, m_cnt;
  bit m_multi, m_prev_high, m_vprev;
  logic [11:0] e_hc, e_vc, e_rgb;
  logic e_hs, e_vs, e_hb, e_vb, e_play, e_mp, e_pr, e_db, e_dm, e_to;
  logic [2:0] e_mode, e_hover;

  function automatic bit hit(int px, int py, int bx, int by, int bw, int bh);
    return px >= bx && px < bx + bw && py >= by && py < by + bh;
  endfunction

  function automatic bit outline(int h, int v, int bx, int by, int bw, int bh);
    return hit(h, v, bx, by, bw, bh) && !hit(h, v, bx + OUTL, by + OUTL, bw - 2 * OUTL, bh - 2 * OUTL);
  endfunction

  function automatic logic [11:0] colour(int st, int h, int v, bit blank, bit hp, bit hn, bit hm);
    bit btn_vis, menu_vis, outer, inner;
    btn_vis  = (st == 0 || st == 2 || st == 3);
    menu_vis = (st == 4 || st == 5);
    outer = h >= LEFTL - BRD && h <= RIGHTL + BRD && v >= TOPL - BRD && v <= BOTL + BRD;
    inner = h >= LEFTL && h <= RIGHTL && v >= TOPL && v <= BOTL;
    if (blank) return 12'h000;
    if (v == 0) return 12'hFF0;
    if (v == 767) return 12'hF00;
    if (h == 0) return 12'h0F0;
    if (h == 1023) return 12'h00F;
    if (btn_vis && outline(h, v, PX, PY, PW, PH)) return hp ? 12'h0F0 : 12'hFFF;
    if (btn_vis && outline(h, v, NX, NY, NW, NH)) return hn ? 12'h0F0 : 12'hFFF;
    if (menu_vis && outline(h, v, MX, MY, MW, MH)) return hm ? 12'h0F0 : 12'hFFF;
    if (st == 1) return (outer && !inner) ? 12'hFFF : 12'h000;
    if (st == 5) return (outer && !inner) ? 12'h888 : 12'h000;
    if (st == 2) return 12'h2F2;
    if (st == 3) return 12'hF22;
    if (st == 4) return 12'h22F;
    return 12'h000;
  endfunction

  task automatic model_edge();
    int nxt;
    bit click, hp, hn, hm, to, nmulti;
    if (!rst_n) begin
      m_state = 0; m_multi = 0; m_prev_high = 1; m_cnt = 0; m_vprev = 0;
      {e_hc, e_vc, e_rgb} = '0;
      {e_hs, e_vs, e_hb, e_vb, e_play, e_mp, e_pr, e_db, e_dm, e_to} = '0;
      e_mode = '0; e_hover = '0;
      return;
    end
    click = mouse_left && !m_prev_high;
    hp = hit(xpos, ypos, PX, PY, PW, PH);
    hn = hit(xpos, ypos, NX, NY, NW, NH);
    hm = hit(xpos, ypos, MX, MY, MW, MH);
    e_rgb = colour(m_state, vid.hcount_in, vid.vcount_in, vid.hblnk_in || vid.vblnk_in, hp, hn, hm);
    e_hc = vid.hcount_in; e_vc = vid.vcount_in;
    e_hs = vid.hsync_in;  e_vs = vid.vsync_in; e_hb = vid.hblnk_in; e_vb = vid.vblnk_in;
    nxt = m_state; nmulti = m_multi; to = 0;
    case (m_state)
      0, 2, 3: begin
        if (game_on) nxt = 1;
        else if (m_state != 0 && menu_on) nxt = 0;
        else if (click && hp) begin nxt = 1; nmulti = 0; end
        else if (click && hn) begin nxt = 4; nmulti = 1; end
        else if (m_state == 0 && game_over) nxt = 3;
        else if (m_state == 0 && victory) nxt = 2;
        else if (m_state != 0 && click) nxt = 0;
      end
      1: begin
        if (menu_on) nxt = 0;
        else if (game_over) nxt = 3;
        else if (victory) nxt = 2;
        else if (pause_toggle) nxt = 5;
      end
      5: if (menu_on || (!pause_toggle && click && hm)) nxt = 0; else if (pause_toggle) nxt = 1;
      4: begin
        if (opponent_ready) nxt = 1;
        else if (click && hm) nxt = 0;
        else if (TO_EN && m_cnt == WAIT_N) begin nxt = 0; to = 1; end
      end
      default: nxt = 0;
    endcase
    if (nxt == 4 && m_state != 4) m_cnt = 0;
    else if (m_state == 4 && vid.vsync_in && !m_vprev) m_cnt++;
    m_vprev = vid.vsync_in;
    m_prev_high = mouse_left;
    e_mode = 3'(nxt);
    e_play = (nxt == 1);
    e_pr   = (nxt == 4);
    e_db   = (nxt == 0 || nxt == 2 || nxt == 3);
    e_dm   = (nxt == 4 || nxt == 5);
    e_mp   = (nxt == 4) || ((nxt == 1 || nxt == 5) && nmulti);
    e_hover = {hm && e_dm, hn && e_db, hp && e_db};
    e_to = to;
    m_state = nxt; m_multi = nmulti;
  endtask

  task automatic step();
    @(posedge pclk);
    model_edge();
    #1;
    check("hcount", vid.hcount_out, e_hc);
    check("vcount", vid.vcount_out, e_vc);
    check("strobes", {vid.hsync_out, vid.vsync_out, vid.hblnk_out, vid.vblnk_out}, {e_hs, e_vs, e_hb, e_vb});
    check("rgb", vid.rgb_out, e_rgb);
    check("mode", mode, e_mode);
    check("play_selected", play_selected, e_play);
    check("multiplayer", multiplayer, e_mp);
    check("player_ready", player_ready, e_pr);
    check("display_buttons", display_buttons, e_db);
    check("display_menu_button", display_menu_button, e_dm);
    check("hover", hover, e_hover);
    check("wait_timeout", wait_timeout, e_to);
  endtask

  task automatic click_at(input int x, input int y);
    xpos = 12'(x); ypos = 12'(y);
    mouse_left = 1'b0; step();
    mouse_left = 1'b1; step();
    mouse_left = 1'b0;
  endtask

  int pulses;

  initial begin
    rst_n = 1'b0; xpos = 12'd440; ypos = 12'd410; mouse_left = 1'b0;
    {game_on, menu_on, game_over, victory, opponent_ready, pause_toggle} = '0;
    vid.hcount_in = 12'd100; vid.vcount_in = 12'd100;
    {vid.hsync_in, vid.vsync_in, vid.hblnk_in, vid.vblnk_in} = '0;

    // reset then hover
    repeat (3) step();
    check("reset_mode", mode, 3'd0);
    check("reset_hover", hover, 3'd0);
    rst_n = 1'b1; step();
    check("first_display_buttons", display_buttons, 1'b1);
    check("first_hover", hover, 3'b001);

    // held button across reset release
    rst_n = 1'b0; mouse_left = 1'b1; step();
    rst_n = 1'b1; repeat (3) step();
    check("held_no_click", mode, 3'd0);
    mouse_left = 1'b0; step();
    mouse_left = 1'b1; step();
    check("reclick_mode", mode, 3'd1);
    check("reclick_play", play_selected, 1'b1);
    mouse_left = 1'b0;

    // pause and return
    pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
    check("pause_mode", mode, 3'd5);
    vid.hcount_in = 12'd361; vid.vcount_in = 12'd317; step();
    check("pause_inside", vid.rgb_out, 12'h000);
    vid.hcount_in = 12'd355; vid.vcount_in = 12'd400; step();
    check("pause_border", vid.rgb_out, 12'h888);
    click_at(440, 530);
    check("pause_menu_click", mode, 3'd0);

    // multiplayer handshake
    click_at(440, 550);
    check("mw_mode", mode, 3'd4);
    check("mw_multi", multiplayer, 1'b1);
    check("mw_ready", player_ready, 1'b1);
    opponent_ready = 1'b1; step(); opponent_ready = 1'b0;
    check("mp_game_mode", mode, 3'd1);
    check("mp_game_multi", multiplayer, 1'b1);

    // timeout
    menu_on = 1'b1; step(); menu_on = 1'b0;
    click_at(440, 550);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      vid.vsync_in = 1'b1; step(); pulses += int'(wait_timeout);
      vid.vsync_in = 1'b0; step(); pulses += int'(wait_timeout);
    end
    repeat (2) begin step(); pulses += int'(wait_timeout); end
    check("timeout_pulses", 32'(pulses), TO_EN ? 32'd1 : 32'd0);
    check("timeout_mode", mode, TO_EN ? 3'd0 : 3'd4);

    // priority
    click_at(440, 530);
    game_on = 1'b1; step(); game_on = 1'b0;
    menu_on = 1'b1; game_over = 1'b1; step(); menu_on = 1'b0; game_over = 1'b0;
    check("prio_menu_over", mode, 3'd0);
    game_on = 1'b1; step(); game_on = 1'b0;
    game_over = 1'b1; step(); game_over = 1'b0;
    check("gameover_mode", mode, 3'd3);
    click_at(10, 10);
    check("click_elsewhere", mode, 3'd0);

    // reset mid-wait
    click_at(440, 550);
    vid.vsync_in = 1'b1; step(); vid.vsync_in = 1'b0; step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (4) step();

    // randomized
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      case ($urandom_range(0, 4))
        0: begin xpos = 12'($urandom_range(PX - 3, PX + PW + 2)); ypos = 12'($urandom_range(PY - 3, PY + PH + 2)); end
        1: begin xpos = 12'($urandom_range(NX - 3, NX + NW + 2)); ypos = 12'($urandom_range(NY - 3, NY + NH + 2)); end
        2: begin xpos = 12'($urandom_range(MX - 3, MX + MW + 2)); ypos = 12'($urandom_range(MY - 3, MY + MH + 2)); end
        default: begin xpos = 12'($urandom_range(0, 1023)); ypos = 12'($urandom_range(0, 767)); end
      endcase
      if ($urandom_range(0, 2) == 0) mouse_left = ~mouse_left;
      game_on        = ($urandom_range(0, 24) == 0);
      menu_on        = ($urandom_range(0, 24) == 0);
      game_over      = ($urandom_range(0, 24) == 0);
      victory        = ($urandom_range(0, 24) == 0);
      opponent_ready = ($urandom_range(0, 29) == 0);
      pause_toggle   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) vid.vsync_in = ~vid.vsync_in;
      vid.hsync_in = 1'($urandom_range(0, 1));
      vid.hblnk_in = ($urandom_range(0, 7) == 0);
      vid.vblnk_in = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0: begin vid.hcount_in = xpos + 12'($urandom_range(0, 4)) - 12'd2; vid.vcount_in = ypos; end
        1: begin vid.hcount_in = 12'($urandom_range(LEFTL - 12, LEFTL + 2)); vid.vcount_in = 12'($urandom_range(TOPL - 12, BOTL + 12)); end
        2: begin vid.hcount_in = 12'($urandom_range(LEFTL - 12, RIGHTL + 12)); vid.vcount_in = 12'($urandom_range(BOTL - 2, BOTL + 12)); end
        3: begin vid.hcount_in = ($urandom_range(0, 1) == 0) ? 12'd0 : 12'd1023; vid.vcount_in = 12'($urandom_range(0, 767)); end
        4: begin vid.hcount_in = 12'($urandom_range(0, 1023)); vid.vcount_in = ($urandom_range(0, 1) == 0) ? 12'd0 : 12'd767; end
        default: begin vid.hcount_in = 12'($urandom_range(0, 1100)); vid.vcount_in = 12'($urandom_range(0, 800)); end
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
